// File: rtl/fifo_1r1w_small.sv
// rtl/fifo_1r1w_small.sv - small single-clock 1-read/1-write FIFO with valid/ready enqueue and valid/yumi dequeue
//
// Parameters:
//   width_p  payload width in bits (>= 1)
//   els_p    storage depth in entries (>= 2, any integer)
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous active-high reset
//   data_i   enqueue payload
//   v_i      enqueue request, accepted when ready_o is high
//   ready_o  at least one free entry exists (registered)
//   data_o   head-of-queue payload, valid only while v_o is high
//   v_o      at least one entry is stored (registered)
//   yumi_i   dequeue acknowledge for the current head, honoured when v_o is high

module fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

  logic [width_p-1:0] mem_r [els_p];

  logic [ptr_w-1:0] wptr_r;
  logic [ptr_w-1:0] rptr_r;
  logic [cnt_w-1:0] cnt_r;
  logic [cnt_w-1:0] cnt_n;
  logic             full_r;
  logic             empty_r;

  logic enq;
  logic deq;

  // Handshakes are qualified by registered flags only, so a full FIFO
  // refuses an enqueue even when the head is being dequeued that cycle.
  assign enq = v_i & ~full_r;
  assign deq = yumi_i & ~empty_r;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign data_o  = mem_r[rptr_r];

  // Pointers wrap explicitly so depths that are not powers of two work.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

  always_comb begin
    cnt_n = cnt_r;
    if (enq && !deq) begin
      cnt_n = cnt_r + cnt_w'(1);
    end else if (deq && !enq) begin
      cnt_n = cnt_r - cnt_w'(1);
    end
  end

  // Full/empty are registered from the next occupancy so the outputs
  // carry no combinational path from v_i or yumi_i.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      cnt_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (deq) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      cnt_r   <= cnt_n;
      full_r  <= (cnt_n == full_cnt);
      empty_r <= (cnt_n == '0);
    end
  end

  // Storage is not reset; only written entries are ever presented as valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && enq) begin
      mem_r[wptr_r] <= data_i;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (v_i && full_r) begin
        $display("ERROR: fifo overflow");
      end
      if (yumi_i && empty_r) begin
        $display("ERROR: fifo underflow");
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_1r1w_small.sv
// tb/tb_fifo_1r1w_small.sv - directed self-checking bench for fifo_1r1w_small

module tb_fifo_1r1w_small;

  logic       clk_i;
  logic       reset_i;
  logic [7:0] data_i;
  logic       v_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       v_o;
  logic       yumi_i;

  int n_cmp;
  int n_bad;

  fifo_1r1w_small #(
    .width_p(8),
    .els_p  (4)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (data_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .v_o    (v_o),
    .yumi_i (yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [7:0] d);
    v_i    = 1'b1;
    data_i = d;
    step();
    v_i    = 1'b0;
  endtask

  task automatic deq_check(input string tag, input logic [7:0] exp);
    check({tag, "_v"}, {7'b0, v_o}, 8'h01);
    check({tag, "_data"}, data_o, exp);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = 8'h00;
    step();
    step();
    reset_i = 1'b0;
    check("reset_v", {7'b0, v_o}, 8'h00);
    check("reset_ready", {7'b0, ready_o}, 8'h01);

    // single entry, latency one, then drain
    enq(8'hA5);
    check("a5_v", {7'b0, v_o}, 8'h01);
    check("a5_data", data_o, 8'hA5);
    check("a5_ready", {7'b0, ready_o}, 8'h01);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    check("a5_drained_v", {7'b0, v_o}, 8'h00);

    // fill to full, overflow dropped, ordered drain
    enq(8'h01);
    enq(8'h02);
    enq(8'h03);
    check("fill3_ready", {7'b0, ready_o}, 8'h01);
    enq(8'h04);
    check("full_ready", {7'b0, ready_o}, 8'h00);
    enq(8'hFF);
    check("ovf_ready", {7'b0, ready_o}, 8'h00);
    deq_check("ovf_d1", 8'h01);
    deq_check("ovf_d2", 8'h02);
    deq_check("ovf_d3", 8'h03);
    deq_check("ovf_d4", 8'h04);
    check("ovf_empty_v", {7'b0, v_o}, 8'h00);
    check("ovf_empty_ready", {7'b0, ready_o}, 8'h01);

    // full with simultaneous yumi and v_i: enqueue refused
    enq(8'h11);
    enq(8'h12);
    enq(8'h13);
    enq(8'h14);
    v_i    = 1'b1;
    data_i = 8'h55;
    yumi_i = 1'b1;
    step();
    v_i    = 1'b0;
    yumi_i = 1'b0;
    check("fullsim_ready", {7'b0, ready_o}, 8'h01);
    check("fullsim_head", data_o, 8'h12);
    enq(8'h55);
    check("fullsim_refull", {7'b0, ready_o}, 8'h00);
    deq_check("fullsim_d2", 8'h12);
    deq_check("fullsim_d3", 8'h13);
    deq_check("fullsim_d4", 8'h14);
    deq_check("fullsim_d5", 8'h55);
    check("fullsim_empty_v", {7'b0, v_o}, 8'h00);

    // streaming: occupancy stays at one, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      v_i    = 1'b1;
      data_i = 8'(i);
      yumi_i = (i != 0);
      if (i != 0) begin
        check("stream_v", {7'b0, v_o}, 8'h01);
        check("stream_data", data_o, 8'(i - 1));
      end
      check("stream_ready", {7'b0, ready_o}, 8'h01);
      step();
    end
    v_i = 1'b0;
    deq_check("stream_last", 8'd19);
    check("stream_empty_v", {7'b0, v_o}, 8'h00);

    // reset mid-stream beats simultaneous v_i and yumi_i
    enq(8'h21);
    enq(8'h22);
    enq(8'h23);
    reset_i = 1'b1;
    v_i     = 1'b1;
    data_i  = 8'h77;
    yumi_i  = 1'b1;
    step();
    reset_i = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    check("midrst_v", {7'b0, v_o}, 8'h00);
    check("midrst_ready", {7'b0, ready_o}, 8'h01);
    enq(8'h3C);
    deq_check("midrst_only", 8'h3C);
    check("midrst_empty_v", {7'b0, v_o}, 8'h00);

    // underflow ignored
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    check("unf_v", {7'b0, v_o}, 8'h00);
    check("unf_ready", {7'b0, ready_o}, 8'h01);
    enq(8'h09);
    enq(8'h0A);
    deq_check("unf_d1", 8'h09);
    deq_check("unf_d2", 8'h0A);
    check("unf_empty_v", {7'b0, v_o}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_1r1w_small.md
FIFO_1R1W_SMALL -- requirements
Module: fifo_1r1w_small

Interface
REQ-001 SHALL have parameter width_p, default 8: payload width in bits (>=1).
REQ-002 SHALL have parameter els_p, default 4: storage depth in entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port data_i, input, width_p: enqueue payload.
REQ-006 SHALL have port v_i, input, 1: enqueue request.
REQ-007 SHALL have port ready_o, output, 1: high when at least one free entry exists.
REQ-008 SHALL have port data_o, output, width_p: head-of-queue payload.
REQ-009 SHALL have port v_o, output, 1: high when at least one entry is stored.
REQ-010 SHALL have port yumi_i, input, 1: dequeue acknowledge for the current head.

Function
REQ-011 SHALL enqueue data_i at the tail on a rising edge iff v_i & ready_o.
REQ-012 SHALL ignore v_i while ready_o=0: no state change, payload dropped; simulation-only code SHALL print "ERROR: fifo overflow" on that edge.
REQ-013 SHALL dequeue the head on a rising edge iff yumi_i & v_o; yumi_i while v_o=0 SHALL be ignored (no state change) and flagged in simulation as "ERROR: fifo underflow".
REQ-014 SHALL preserve strict FIFO order; payloads SHALL emerge bit-exact.
REQ-015 SHALL drive data_o combinationally from the head storage entry; data_o is don't-care while v_o=0.
REQ-016 SHALL NOT bypass: an entry written into an empty FIFO raises v_o one cycle after the enqueue edge (latency 1).
REQ-017 SHALL derive ready_o and v_o only from registered state (no combinational path from v_i or yumi_i to any output).
REQ-018 SHALL track occupancy 0..els_p using read/write pointers in 0..els_p-1 that wrap from els_p-1 to 0, plus a full/empty disambiguation bit or counter.
REQ-019 Simultaneous enqueue and dequeue on one edge (neither full nor empty) SHALL leave occupancy unchanged and advance both pointers.
REQ-020 When full, ready_o=0 even if yumi_i=1 in the same cycle; the freed slot becomes available (ready_o=1) next cycle.
REQ-021 When occupancy is 1 and dequeue plus enqueue occur together, v_o SHALL stay 1 and data_o SHALL show the new entry next cycle.
REQ-022 Storage SHALL be a register array of els_p x width_p written only on enqueue; storage contents need not be reset.

Reset
REQ-023 While reset_i=1 at an edge, pointers and occupancy SHALL clear: v_o=0, ready_o=1 the following cycle.
REQ-024 Reset SHALL take priority over simultaneous v_i/yumi_i; entries present before reset are discarded, including mid-stream.
REQ-025 After reset deasserts, the first enqueue SHALL be accepted on the first edge with v_i=1.

Verification (width_p=8, els_p=4)
REQ-026 Reset, then v_i=1 data 0xA5 for one cycle -> next cycle v_o=1, data_o=0xA5, ready_o=1; yumi_i=1 -> next cycle v_o=0.
REQ-027 Enqueue 0x01,0x02,0x03,0x04 back-to-back -> ready_o=0 after fourth; extra v_i with 0xFF dropped, error printed; dequeue yields 0x01..0x04 in order, then v_o=0.
REQ-028 Full FIFO, yumi_i=1 and v_i=1 (0x55) same cycle -> 0x55 not stored, ready_o=1 next cycle; subsequent enqueue of 0x55 accepted and emerges fifth.
REQ-029 Continuous streaming with v_i=1 and yumi_i=v_o for 20 cycles, data 0..19 -> all 20 values out in order, occupancy never exceeds 1, pointers wrap correctly.
REQ-030 Fill with 3 entries, assert reset_i one cycle with v_i=1 and yumi_i=1 -> v_o=0, ready_o=1 next cycle; next enqueue 0x3C is the only output.
REQ-031 Empty FIFO, yumi_i=1 -> no state change, v_o stays 0, underflow error printed.
